// File: rtl/r2r_dac_pkg.sv
// Shared types and constants for the R2R ladder sequencer.
// Holds the source-select and FSM encodings plus the triangle step helper.
package r2r_dac_pkg;

    localparam int DAC_W = 8;
    localparam logic [DAC_W-1:0] DAC_RESET_CODE = 8'h00;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_RAMP   = 2'b01,
        MODE_FIFO   = 2'b10,
        MODE_TRI    = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Returns {next_up, next_code}. An endpoint reached while heading into it
    // still bounces back instead of wrapping.
    function automatic logic [DAC_W:0] tri_step(input logic [DAC_W-1:0] code,
                                                input logic up);
        logic [DAC_W-1:0] nxt;
        logic             nup;
        if (up) begin
            nxt = (code == '1) ? code - 1'b1 : code + 1'b1;
        end else begin
            nxt = (code == '0) ? code + 1'b1 : code - 1'b1;
        end
        if (nxt == '1) begin
            nup = 1'b0;
        end else if (nxt == '0) begin
            nup = 1'b1;
        end else begin
            nup = (nxt > code);
        end
        return {nup, nxt};
    endfunction

endpackage

// File: rtl/r2r_sample_fifo.sv
// Small synchronous sample FIFO feeding the sequencer in FIFO mode.
// Push when full and pop when empty are ignored; flush wins over both.
module r2r_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= wr_data;
        end
    end

endmodule

// File: rtl/r2r_dac_sequencer.sv
// R2R ladder code sequencer: divider-paced sample ticks drawing codes from
// a held input, ramp, triangle or host-loaded FIFO.
module r2r_dac_sequencer
    import r2r_dac_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic [1:0]               mode,
    input  logic [DIV_W-1:0]         div,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     flush,
    input  logic                     clr_underrun,
    output logic [7:0]               dac_code,
    output logic                     sample_tick,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    state_t           state;
    mode_t            mode_sel;
    logic [DIV_W-1:0] cnt;
    logic             dir_up;
    logic             tick;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DAC_W-1:0] fifo_rd;
    logic [DAC_W-1:0] next_code;
    logic             next_up;
    logic             uflow;
    logic [DAC_W:0]   tri_nxt;

    assign mode_sel = mode_t'(mode);
    // Gating on run drops a tick that would coincide with leaving PLAY.
    assign tick     = (state == ST_PLAY) && run && (cnt >= div);
    assign fifo_pop = tick && (mode_sel == MODE_FIFO);
    assign wr_ready = !fifo_full;
    assign tri_nxt  = tri_step(dac_code, dir_up);

    r2r_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (DAC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_valid),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data (wr_data),
        .rd_data (fifo_rd),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        next_code = dac_code;
        next_up   = dir_up;
        uflow     = 1'b0;
        case (mode_sel)
            MODE_DIRECT: next_code = wr_data;
            MODE_RAMP:   next_code = dac_code + 1'b1;
            MODE_TRI: begin
                next_code = tri_nxt[DAC_W-1:0];
                next_up   = tri_nxt[DAC_W];
            end
            MODE_FIFO: begin
                if (fifo_empty) begin
                    uflow = 1'b1;
                end else begin
                    next_code = fifo_rd;
                end
            end
            default: next_code = dac_code;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dir_up      <= 1'b1;
            dac_code    <= DAC_RESET_CODE;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (run)  state <= ST_PLAY;
                ST_PLAY: if (!run) state <= ST_IDLE;
                default:           state <= ST_IDLE;
            endcase

            if ((state == ST_PLAY) && run) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            sample_tick <= tick;
            if (tick) begin
                dac_code <= next_code;
                dir_up   <= next_up;
            end

            if (tick && uflow) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Scoreboard bench for r2r_dac_sequencer: a behavioural model predicts each
// sample tick, and a negedge monitor compares the DUT against it.
module tb_r2r_dac_sequencer;
    localparam int DIV_W = 16;
    localparam int DEPTH = 16;

    logic                   clk;
    logic                   rst_n;
    logic                   run;
    logic [1:0]             mode;
    logic [DIV_W-1:0]       div;
    logic [7:0]             wr_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic                   flush;
    logic                   clr_underrun;
    logic [7:0]             dac_code;
    logic                   sample_tick;
    logic                   underrun;
    logic [$clog2(DEPTH):0] fifo_level;

    r2r_dac_sequencer #(
        .DIV_W (DIV_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .mode         (mode),
        .div          (div),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .flush        (flush),
        .clr_underrun (clr_underrun),
        .dac_code     (dac_code),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sample stream derived from the rules of each source.
    typedef struct {
        int cyc;
        int code;
        int uflow;
    } exp_t;

    exp_t sb[$];
    int   m_q[$];
    int   m_cyc;
    bit   m_play;
    int   m_wait;
    int   m_code;
    bit   m_up;
    bit   m_uflow;
    bit   m_fire;
    bit   m_room;
    bit   m_ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   = 0;
            m_play  = 0;
            m_wait  = 0;
            m_code  = 0;
            m_up    = 1;
            m_uflow = 0;
            m_q.delete();
            sb.delete();
        end else begin
            m_cyc++;
            m_fire = 0;
            m_ev   = 0;
            m_room = (m_q.size() < DEPTH);
            if (!m_play) begin
                m_play = run;
                m_wait = 0;
            end else if (!run) begin
                m_play = 0;
                m_wait = 0;
            end else if (m_wait >= int'(div)) begin
                m_fire = 1;
                m_wait = 0;
            end else begin
                m_wait++;
            end
            if (m_fire) begin
                case (mode)
                    2'b00: m_code = wr_data;
                    2'b01: m_code = (m_code + 1) % 256;
                    2'b10: begin
                        if (m_q.size() == 0) m_ev = 1;
                        else m_code = m_q.pop_front();
                    end
                    default: begin
                        if (m_up) begin
                            if (m_code == 255) begin m_code = 254; m_up = 0; end
                            else m_code = m_code + 1;
                        end else begin
                            if (m_code == 0) begin m_code = 1; m_up = 1; end
                            else m_code = m_code - 1;
                        end
                        if (m_code == 255) m_up = 0;
                        if (m_code == 0)   m_up = 1;
                    end
                endcase
            end
            if (wr_valid && m_room) m_q.push_back(int'(wr_data));
            if (flush) m_q.delete();
            if (m_ev) m_uflow = 1;
            else if (clr_underrun) m_uflow = 0;
            if (m_fire) sb.push_back('{m_cyc, m_code, int'(m_ev)});
        end
    end

    exp_t e;
    bit   exp_tick;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_tick = (sb.size() > 0) && (sb[0].cyc == m_cyc);
            chk("sample_tick", int'(sample_tick), int'(exp_tick));
            if (exp_tick) begin
                e = sb.pop_front();
                chk("tick_code", int'(dac_code), e.code);
                if (e.uflow != 0) chk("tick_underrun", int'(underrun), 1);
            end else if (sb.size() > 0 && sb[0].cyc < m_cyc) begin
                void'(sb.pop_front());
            end
            chk("dac_code", int'(dac_code), m_code);
            chk("underrun", int'(underrun), int'(m_uflow));
            chk("fifo_level", int'(fifo_level), m_q.size());
            chk("wr_ready", int'(wr_ready), int'(m_q.size() < DEPTH));
        end
    end

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (sample_tick) return;
        end
        checks++;
        errors++;
        $display("FAIL tick_timeout: got none expected tick within %0d cycles", maxc);
        n = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dac_code"}, int'(dac_code), 0);
        chk({tag, "_sample_tick"}, int'(sample_tick), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_wr_ready"}, int'(wr_ready), 1);
        chk({tag, "_fifo_level"}, int'(fifo_level), 0);
    endtask

    initial begin
        int n;
        int codes[4];
        int found;

        rst_n = 0; run = 0; mode = 2'b00; div = '0; wr_data = '0;
        wr_valid = 0; flush = 0; clr_underrun = 0;
        #23;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1;
        idle(2);

        // Ramp, div=3: first tick latency, period, wrap.
        mode = 2'b01; div = 16'd3; run = 1;
        wait_tick(20, n);
        chk("ramp_first_latency", n, 5);
        chk("ramp_first_code", int'(dac_code), 1);
        for (int t = 2; t <= 256; t++) begin
            wait_tick(10, n);
            chk("ramp_period", n, 4);
            if (t == 255) chk("ramp_255", int'(dac_code), 255);
        end
        chk("ramp_wrap", int'(dac_code), 0);

        // Triangle from 253 upward, then through the bottom endpoint.
        mode = 2'b00; wr_data = 8'd253;
        wait_tick(10, n);
        chk("direct_253", int'(dac_code), 253);
        mode = 2'b11; div = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            codes[i] = int'(dac_code);
        end
        chk("tri_0", codes[0], 254);
        chk("tri_1", codes[1], 255);
        chk("tri_2", codes[2], 254);
        chk("tri_3", codes[3], 253);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (dac_code == 8'd1) found = 1;
        end
        chk("tri_reach_1", found, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            codes[i] = int'(dac_code);
        end
        chk("tri_low_0", codes[0], 0);
        chk("tri_low_1", codes[1], 1);
        chk("tri_low_2", codes[2], 2);

        // FIFO playback and underrun.
        run = 0;
        idle(2);
        foreach (codes[i]) codes[i] = 0;
        wr_valid = 1; wr_data = 8'h11; @(negedge clk);
        wr_data = 8'h22; @(negedge clk);
        wr_data = 8'h33; @(negedge clk);
        wr_valid = 0;
        chk("fifo_loaded", int'(fifo_level), 3);
        mode = 2'b10; div = 16'd1; run = 1;
        for (int i = 0; i < 4; i++) begin
            wait_tick(10, n);
            codes[i] = int'(dac_code);
            if (i == 2) chk("fifo_no_underrun_yet", int'(underrun), 0);
        end
        chk("fifo_0", codes[0], 8'h11);
        chk("fifo_1", codes[1], 8'h22);
        chk("fifo_2", codes[2], 8'h33);
        chk("fifo_hold", codes[3], 8'h33);
        chk("fifo_underrun_set", int'(underrun), 1);
        run = 0;
        @(negedge clk);
        clr_underrun = 1;
        @(negedge clk);
        clr_underrun = 0;
        chk("underrun_cleared", int'(underrun), 0);

        // Fill to full with run low, overfill, then flush.
        wr_valid = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr_data = 8'(8'h40 + i);
            @(negedge clk);
        end
        wr_valid = 0;
        chk("full_level", int'(fifo_level), DEPTH);
        chk("full_wr_ready", int'(wr_ready), 0);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_level", int'(fifo_level), 0);
        chk("flush_wr_ready", int'(wr_ready), 1);

        // Direct mode with a mid-count divider reduction.
        mode = 2'b00; div = 16'd9; wr_data = 8'h5A; run = 1;
        wait_tick(20, n);
        chk("direct_code", int'(dac_code), 8'h5A);
        idle(5);
        div = 16'd2; wr_data = 8'hC3;
        wait_tick(5, n);
        chk("div_shrink_immediate", n, 1);
        chk("direct_follow", int'(dac_code), 8'hC3);
        wr_data = 8'h3C;
        wait_tick(10, n);
        chk("div_shrink_period", n, 3);
        chk("direct_follow2", int'(dac_code), 8'h3C);

        // Asynchronous reset mid-PLAY with five entries queued.
        run = 0;
        idle(2);
        wr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(i + 1);
            @(negedge clk);
        end
        wr_valid = 0;
        chk("pre_reset_level", int'(fifo_level), 5);
        mode = 2'b01; div = 16'd0; run = 1;
        idle(3);
        #2 rst_n = 0;
        #1 check_reset_values("async_rst");
        run = 0;
        @(negedge clk);
        rst_n = 1; div = 16'd4; mode = 2'b01; run = 1;
        wait_tick(20, n);
        chk("post_reset_latency", n, 6);
        chk("post_reset_code", int'(dac_code), 1);

        // Randomized phase; flush only while run is low so it never meets a pop.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            run          = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  div  = DIV_W'($urandom_range(0, 4));
            wr_valid     = ($urandom_range(0, 2) != 0);
            wr_data      = 8'($urandom);
            clr_underrun = ($urandom_range(0, 15) == 0);
            flush        = !run && ($urandom_range(0, 3) == 0);
        end
        run = 0; wr_valid = 0; flush = 0; clr_underrun = 0;
        idle(4);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
